// File: rtl/serial_frame_rx.sv
// Serial frame receiver: 8N1 MSB-first deserialiser with rotating channel tag,
// valid/ready output, dsr back-pressure and sticky error flags.
// Define SERIAL_RX_GLITCH_FILTER_EN to add a 2-of-3 majority filter on the synchronised line.
module serial_frame_rx #(
  parameter int BIT_CYCLES = 106,
  parameter int CNT_W      = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic [2:0] rx_channel,
  output logic       rx_valid,
  output logic       dsr,
  output logic       frame_error,
  output logic       overrun
);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             line_s;
  logic             line_m;
  logic             prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [2:0]       chan;

  // NOTE: synchroniser flops reset to the idle level (1) so releasing reset
  // never looks like a falling start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], serial_in};
  end
  assign line_s = sync_q[1];

`ifdef SERIAL_RX_GLITCH_FILTER_EN
  logic [1:0] hist;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hist <= 2'b11;
    else          hist <= {hist[0], line_s};
  end
  assign line_m = (line_s & hist[0]) | (line_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign line_m = line_s;
`endif

  logic stop_tick, good_stop, bad_stop, accept, load, rx_valid_next;

  assign stop_tick     = (state == R_STOP) && (timer == FULL_M1);
  assign good_stop     = stop_tick & line_m;
  assign bad_stop      = stop_tick & ~line_m;
  assign accept        = rx_valid & rx_ready;
  assign load          = good_stop & (~rx_valid | accept);
  assign rx_valid_next = load | (rx_valid & ~rx_ready);

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= R_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      prev    <= 1'b1;
    end else begin
      prev <= line_m;
      case (state)
        R_IDLE: begin
          if (prev && !line_m) begin
            state <= R_START;
            timer <= '0;
          end
        end
        R_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            if (!line_m) begin
              state   <= R_DATA;
              bit_cnt <= '0;
            end else begin
              state <= R_IDLE;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        R_DATA: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            shreg <= {shreg[6:0], line_m};
            if (bit_cnt == 3'd7) state <= R_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        default: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            state <= R_IDLE;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Channel tag advances on every well-formed frame, even one dropped by overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_channel  <= '0;
      rx_valid    <= 1'b0;
      dsr         <= 1'b1;
      chan        <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_valid <= rx_valid_next;
      dsr      <= ~rx_valid_next;
      if (load) begin
        rx_data    <= shreg;
        rx_channel <= chan;
      end
      if (good_stop) chan <= chan + 3'd1;

      if (bad_stop)     frame_error <= 1'b1;
      else if (err_clr) frame_error <= 1'b0;

      if (good_stop && !load) overrun <= 1'b1;
      else if (err_clr)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx at BIT_CYCLES=16; accepted bytes are
// popped from an expectation queue by a negedge monitor.
module tb_serial_frame_rx;

  localparam int BC = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic [2:0] rx_channel;
  logic       rx_valid;
  logic       dsr;
  logic       frame_error;
  logic       overrun;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] chan;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_chan = 3'd0;

  serial_frame_rx #(.BIT_CYCLES(BC), .CNT_W(10)) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .rx_ready(rx_ready),
    .err_clr(err_clr), .rx_data(rx_data), .rx_channel(rx_channel), .rx_valid(rx_valid),
    .dsr(dsr), .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every accepted byte must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && rx_valid && rx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rx: got data=%h chan=%0d, expected no output", rx_data, rx_channel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rx_data, rx_channel} !== {e.data, e.chan}) begin
          failures++;
          $display("FAIL rx_byte: got data=%h chan=%0d, expected data=%h chan=%0d",
                   rx_data, rx_channel, e.data, e.chan);
        end
      end
      checks++;
      if (dsr !== 1'b0) begin
        failures++;
        $display("FAIL dsr_while_valid: got %b, expected 0", dsr);
      end
    end
  end

  function automatic logic line_bit(input logic [7:0] b, input logic stop, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[8-idx];
    if (idx == 9) return stop;
    return 1'b1;
  endfunction

  task automatic expect_frame(input logic [7:0] b);
    exp_t e;
    e.data = b;
    e.chan = exp_chan;
    sb.push_back(e);
    exp_chan = exp_chan + 3'd1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the frame and idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
    for (int i = 0; i < 10; i++) begin
      serial_in = line_bit(b, stop, i);
      repeat (BC) @(posedge clock);
      #1;
    end
    serial_in = 1'b1;
    repeat (idle) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_chan = 3'd0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
    checks++; if (dsr !== 1'b1)         begin failures++; $display("FAIL reset_dsr: got %b, expected 1", dsr); end
    checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL reset_data: got %h, expected 00", rx_data); end
    checks++; if (rx_channel !== 3'd0)  begin failures++; $display("FAIL reset_chan: got %0d, expected 0", rx_channel); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b, expected 0", frame_error); end
    checks++; if (overrun !== 1'b0)     begin failures++; $display("FAIL reset_ovr: got %b, expected 0", overrun); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    int first;
    int vcnt;
    logic flags;
    first = 0;
    vcnt = 0;
    flags = 1'b0;
    rx_ready = 1'b1;
    expect_frame(8'hA5);
    for (int e = 1; e <= 175; e++) begin
      serial_in = line_bit(8'hA5, 1'b1, (e - 1) / BC);
      @(posedge clock);
      #1;
      if (rx_valid) begin
        vcnt++;
        if (first == 0) first = e;
      end
      if (frame_error || overrun) flags = 1'b1;
    end
    serial_in = 1'b1;
    checks++; if (first != 155) begin failures++; $display("FAIL single_latency: got edge %0d, expected 155", first); end
    checks++; if (vcnt != 1)    begin failures++; $display("FAIL single_valid_len: got %0d cycles, expected 1", vcnt); end
    checks++; if (flags !== 1'b0) begin failures++; $display("FAIL single_flags: got %b, expected 0", flags); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rx_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      expect_frame(8'(i));
      send_frame(8'(i), 1'b1, 0);
      checks++;
      if (dsr !== 1'b1) begin failures++; $display("FAIL b2b_dsr frame %0d: got %b, expected 1", i, dsr); end
    end
    repeat (4) @(posedge clock);
    #1;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    expect_frame(8'h11);
    send_frame(8'h11, 1'b1, 4);
    exp_chan = exp_chan + 3'd1;  // 0x22 is dropped but still consumes a tag
    send_frame(8'h22, 1'b1, 4);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b, expected 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data: got %h, expected 11", rx_data); end
    checks++; if (overrun !== 1'b1)  begin failures++; $display("FAIL ovr_flag: got %b, expected 1", overrun); end
    checks++; if (dsr !== 1'b0)      begin failures++; $display("FAIL ovr_dsr: got %b, expected 0", dsr); end
    err_clr = 1'b1;
    @(posedge clock);
    #1 err_clr = 1'b0;
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold: got %b, expected 1", rx_valid); end
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid: got %b, expected 0", rx_valid); end
    checks++; if (dsr !== 1'b1)      begin failures++; $display("FAIL ovr_drain_dsr: got %b, expected 1", dsr); end
  endtask

  task automatic test_glitch();
    logic saw_start;
    logic any_out;
    saw_start = 1'b0;
    any_out = 1'b0;
`ifdef SERIAL_RX_GLITCH_FILTER_EN
    serial_in = 1'b0;
    @(posedge clock);
    #1 serial_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (dut.state !== 2'd0) saw_start = 1'b1;
    end
    checks++; if (saw_start !== 1'b0) begin failures++; $display("FAIL glitch1_left_idle: got %b, expected 0", saw_start); end
`endif
    serial_in = 1'b0;
    repeat (3) @(posedge clock);
    #1 serial_in = 1'b1;
    saw_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (dut.state !== 2'd0) saw_start = 1'b1;
      if (rx_valid || frame_error || overrun) any_out = 1'b1;
    end
    checks++; if (saw_start !== 1'b1)   begin failures++; $display("FAIL glitch3_no_start: got %b, expected 1", saw_start); end
    checks++; if (dut.state !== 2'd0)   begin failures++; $display("FAIL glitch3_state: got %0d, expected 0", dut.state); end
    checks++; if (any_out !== 1'b0)     begin failures++; $display("FAIL glitch3_outputs: got %b, expected 0", any_out); end
  endtask

  task automatic test_frame_error();
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 20);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b, expected 1", frame_error); end
    checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL ferr_valid: got %b, expected 0", rx_valid); end
    expect_frame(8'h3D);
    send_frame(8'h3D, 1'b1, 4);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b, expected 1", frame_error); end
    checks++; if (rx_channel !== 3'd3)  begin failures++; $display("FAIL ferr_chan: got %0d, expected 3", rx_channel); end
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serial_in = line_bit(8'h5A, 1'b1, i);
      repeat (BC) @(posedge clock);
      #1;
    end
    serial_in = line_bit(8'h5A, 1'b1, 5);
    repeat (BC / 2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL mid_data: got %h, expected 00", rx_data); end
    checks++; if (rx_channel !== 3'd0)  begin failures++; $display("FAIL mid_chan: got %0d, expected 0", rx_channel); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL mid_ferr: got %b, expected 0", frame_error); end
    checks++; if ({rx_valid, dsr, overrun} !== 3'b010) begin
      failures++; $display("FAIL mid_ctrl: got valid/dsr/ovr=%b, expected 010", {rx_valid, dsr, overrun});
    end
    serial_in = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_chan = 3'd0;
    repeat (5) @(posedge clock);
    #1;
    expect_frame(8'h5A);
    send_frame(8'h5A, 1'b1, 4);
    checks++; if (rx_channel !== 3'd0) begin failures++; $display("FAIL mid_after_chan: got %0d, expected 0", rx_channel); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending frames, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
